pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack_pkg.sv | 17 +
 rtl/pc_stack_ret_stack.sv | 56 +++++
 rtl/pc_stack.sv | 118 +++++++++++
 tb/tb_pc_stack.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared types for the PC / return-stack block: operation enum and the
// load_PC/call/ret/INC_PC priority decode.
package pc_stack_pkg;

  typedef enum logic [2:0] {HOLD, INC, BRANCH, CALL, RET} pc_op_t;

  // call beats ret beats INC_PC beats a plain branch; nothing happens without load.
  function automatic pc_op_t decode_op(input logic load, input logic inc,
                                       input logic call, input logic ret);
    if (!load)     return HOLD;
    else if (call) return CALL;
    else if (ret)  return RET;
    else if (inc)  return INC;
    else           return BRANCH;
  endfunction

endpackage

// File: rtl/pc_stack_ret_stack.sv
// LIFO of return addresses with a circular write pointer; a push while full
// overwrites the oldest entry and leaves the count saturated at DEPTH.
module ret_stack
  import pc_stack_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] top_idx;

  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    if (push) begin
      wp_d = wp_q + PW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end else if (pop && count_q != '0) begin
      wp_d    = wp_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Entries are never cleared; the count alone defines what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wp_q] <= din;
  end

  assign top_idx = wp_q - PW'(1);
  assign dout    = mem_q[top_idx];
  assign count   = count_q;

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack. Define PC_STACK_GUARD_EN to refuse
// overflowing calls / empty returns and raise a sticky stack_err.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4,
  localparam int AW    = WORD_W - OP_W,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_PC,
  input  logic          INC_PC,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] branchaddr,
  output logic [AW-1:0] Iaddress,
  output logic [CW-1:0] sp_count,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          stack_err
);

  pc_op_t        op;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] stack_top;
  logic          push, pop;

  assign op          = decode_op(load_PC, INC_PC, call, ret);
  assign ret_addr    = iaddr_q + AW'(1);
  assign stack_full  = (sp_count == CW'(DEPTH));
  assign stack_empty = (sp_count == '0);

`ifdef PC_STACK_GUARD_EN
  logic err_q, err_d;

  always_comb begin
    iaddr_d = iaddr_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      INC:    iaddr_d = ret_addr;
      BRANCH: iaddr_d = branchaddr;
      CALL: begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push    = 1'b1;
          iaddr_d = branchaddr;
        end
      end
      RET: begin
        if (stack_empty) begin
          err_d = 1'b1;
        end else begin
          pop     = 1'b1;
          iaddr_d = stack_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign stack_err = err_q;
`else
  always_comb begin
    iaddr_d = iaddr_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      INC:    iaddr_d = ret_addr;
      BRANCH: iaddr_d = branchaddr;
      CALL: begin
        push    = 1'b1;
        iaddr_d = branchaddr;
      end
      RET: begin
        // An empty return restarts at address zero.
        pop     = ~stack_empty;
        iaddr_d = stack_empty ? '0 : stack_top;
      end
      default: ;
    endcase
  end

  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) iaddr_q <= '0;
    else       iaddr_q <= iaddr_d;
  end

  assign Iaddress = iaddr_q;

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (stack_top),
    .count (sp_count)
  );

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack (WORD_W=8, OP_W=3, DEPTH=4); honours PC_STACK_GUARD_EN.
module tb_pc_stack;

  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_PC = 1'b0, INC_PC = 1'b0, call = 1'b0, ret = 1'b0;
  logic [AW-1:0] branchaddr = '0;
  logic [AW-1:0] Iaddress;
  logic [2:0]    sp_count;
  logic          stack_full, stack_empty, stack_err;

  pc_stack #(.WORD_W(8), .OP_W(3), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_PC     (load_PC),
    .INC_PC      (INC_PC),
    .call        (call),
    .ret         (ret),
    .branchaddr  (branchaddr),
    .Iaddress    (Iaddress),
    .sp_count    (sp_count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pc;
    int sp;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   m_stack[$];
  int   m_pc  = 0;
  int   m_err = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge.
  task automatic model_step(input bit rst, input bit ld, input bit inc, input bit c,
                            input bit r, input int ba);
    if (rst) begin
      m_pc = 0;
      m_err = 0;
      m_stack.delete();
    end else if (ld) begin
      if (c) begin
        if (m_stack.size() == DEPTH) begin
`ifdef PC_STACK_GUARD_EN
          m_err = 1;
`else
          void'(m_stack.pop_front());
          m_stack.push_back((m_pc + 1) % 32);
          m_pc = ba;
`endif
        end else begin
          m_stack.push_back((m_pc + 1) % 32);
          m_pc = ba;
        end
      end else if (r) begin
        if (m_stack.size() == 0) begin
`ifdef PC_STACK_GUARD_EN
          m_err = 1;
`else
          m_pc = 0;
`endif
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (inc) begin
        m_pc = (m_pc + 1) % 32;
      end else begin
        m_pc = ba;
      end
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic cyc(input string tag, input bit rst, input bit ld, input bit inc,
                     input bit c, input bit r, input int ba);
    exp_t e;
    reset = rst; load_PC = ld; INC_PC = inc; call = c; ret = r;
    branchaddr = AW'(ba);
    model_step(rst, ld, inc, c, r, ba);
    e.pc = m_pc; e.sp = m_stack.size(); e.err = m_err;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".pc"},    32'(Iaddress),    32'(e.pc));
    check_val({tag, ".sp"},    32'(sp_count),    32'(e.sp));
    check_val({tag, ".full"},  32'(stack_full),  32'(e.sp == DEPTH));
    check_val({tag, ".empty"}, 32'(stack_empty), 32'(e.sp == 0));
    check_val({tag, ".err"},   32'(stack_err),   32'(e.err));
    $display("[TB] %-8s rst=%0b ld=%0b inc=%0b call=%0b ret=%0b ba=%0d -> pc=%0d sp=%0d err=%0b",
             tag, rst, ld, inc, c, r, ba, Iaddress, sp_count, stack_err);
  endtask

  initial begin
    @(posedge clock);
    #1;
    cyc("reset", 1, 0, 0, 0, 0, 0);
    check_val("reset_pc", 32'(Iaddress), 32'd0);

    for (int i = 0; i < 33; i++) cyc("inc", 0, 1, 1, 0, 0, 0);
    check_val("inc_wrap", 32'(Iaddress), 32'd1);

    cyc("branch", 0, 1, 0, 0, 0, 5);
    cyc("call", 0, 1, 0, 1, 0, 20);
    check_val("call_tgt", 32'(Iaddress), 32'd20);
    cyc("ret", 0, 1, 0, 0, 1, 0);
    check_val("ret_addr", 32'(Iaddress), 32'd6);

    cyc("branch", 0, 1, 0, 0, 0, 3);
    cyc("prio", 0, 1, 1, 1, 1, 9);
    check_val("prio_pc", 32'(Iaddress), 32'd9);
    check_val("prio_sp", 32'(sp_count), 32'd1);
    cyc("hold", 0, 0, 1, 1, 1, 17);
    cyc("prio_r", 0, 1, 1, 0, 1, 12);
    check_val("prio_r_pc", 32'(Iaddress), 32'd4);

    cyc("branch", 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc("nest", 0, 1, 0, 1, 0, i + 2);
`ifdef PC_STACK_GUARD_EN
    check_val("ovf_pc", 32'(Iaddress), 32'd5);
    check_val("ovf_err", 32'(stack_err), 32'd1);
`else
    check_val("ovf_pc", 32'(Iaddress), 32'd6);
    check_val("ovf_sp", 32'(sp_count), 32'd4);
`endif
    for (int i = 0; i < 4; i++) cyc("unwind", 0, 1, 0, 0, 1, 0);
`ifdef PC_STACK_GUARD_EN
    check_val("unwind_last", 32'(Iaddress), 32'd2);
`else
    check_val("unwind_last", 32'(Iaddress), 32'd3);
`endif

    cyc("reset", 1, 0, 0, 0, 0, 0);
    cyc("branch", 0, 1, 0, 0, 0, 7);
    cyc("ret_emp", 0, 1, 0, 0, 1, 0);
`ifdef PC_STACK_GUARD_EN
    check_val("udf_pc", 32'(Iaddress), 32'd7);
    check_val("udf_err", 32'(stack_err), 32'd1);
`else
    check_val("udf_pc", 32'(Iaddress), 32'd0);
    check_val("udf_err", 32'(stack_err), 32'd0);
`endif

    cyc("reset", 1, 0, 0, 0, 0, 0);
    cyc("call", 0, 1, 0, 1, 0, 10);
    cyc("call", 0, 1, 0, 1, 0, 15);
    cyc("rst_call", 1, 1, 0, 1, 0, 25);
    check_val("rst_call_pc", 32'(Iaddress), 32'd0);
    check_val("rst_call_sp", 32'(sp_count), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      cyc("rand", 0, sel != 0, sel == 3, sel == 4 || sel == 5, sel == 1 || sel == 5,
          $urandom_range(0, 31));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
